// File: rtl/led_seq_ctrl_pkg.sv
// rtl/led_seq_ctrl_pkg.sv - shared constants, state enum and time-base helper
// Purpose: mode encodings, sequencer state enum, cycles-per-ms helper.
// Ports: none (package).
package led_pkg;

  localparam logic [1:0] MODE_OFF    = 2'd0;
  localparam logic [1:0] MODE_ALL_ON = 2'd1;
  localparam logic [1:0] MODE_BLINK  = 2'd2;
  localparam logic [1:0] MODE_CHASE  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SWITCH = 2'd1,
    ST_RUN    = 2'd2
  } state_e;

  function automatic int cycles_per_ms(input int clk_freq_hz);
    return clk_freq_hz / 1000;
  endfunction

endpackage

// File: rtl/led_seq_ctrl_if.sv
// rtl/led_seq_ctrl_if.sv - mode request handshake interface
// Purpose: carries the requested mode and its valid/ready handshake.
// Signals: i_mode (2b requested mode), i_mode_valid, o_mode_ready.
// Modports: master = requester, slave = led_seq_ctrl.
interface led_seq_ctrl_if;
  logic [1:0] i_mode;
  logic       i_mode_valid;
  logic       o_mode_ready;

  modport master (output i_mode, output i_mode_valid, input  o_mode_ready);
  modport slave  (input  i_mode, input  i_mode_valid, output o_mode_ready);
endinterface

// File: rtl/led_seq_ctrl_ms_tick.sv
// rtl/led_seq_ctrl_ms_tick.sv - millisecond prescaler emitting a 1-cycle tick
// Purpose: counts 0..P_CYCLES_PER_MS-1, tick is high while at terminal count.
// Ports: i_clk, i_rst_n (async active-low), i_clear (hold at 0), o_tick.
module led_ms_tick #(
  parameter int P_CYCLES_PER_MS = 5000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  output logic o_tick
);

  localparam int W = (P_CYCLES_PER_MS > 1) ? $clog2(P_CYCLES_PER_MS) : 1;
  localparam logic [W-1:0] LAST = W'(P_CYCLES_PER_MS - 1);

  logic [W-1:0] cnt_q, cnt_d;
  logic         term;

  assign term   = (cnt_q == LAST);
  assign o_tick = term;

  always_comb begin
    cnt_d = cnt_q + W'(1);
    if (i_clear || term) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_seq_ctrl.sv
// rtl/led_seq_ctrl.sv - LED pattern sequencer with mode handshake
// Purpose: accepts a display mode and steps the LED bank through its pattern.
// Ports: i_clk, i_rst_n (async active-low), mode_if (slave: i_mode,
//   i_mode_valid, o_mode_ready), o_mode (running mode), o_led (registered pins).
// Build option: LED_SEQ_BOUNCE_EN makes CHASE bounce instead of wrap.
module led_seq_ctrl
  import led_pkg::*;
#(
  parameter int P_CLK_FREQ_HZ = 5_000_000,
  parameter int P_LED_NUMBER  = 2,
  parameter int P_STEP_MS     = 250,
  parameter bit P_LED_ON      = 1'b1
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  led_seq_ctrl_if.slave           mode_if,
  output logic [1:0]              o_mode,
  output logic [P_LED_NUMBER-1:0] o_led
);

  localparam int CPM = cycles_per_ms(P_CLK_FREQ_HZ);
  localparam int SW  = (P_STEP_MS > 1) ? $clog2(P_STEP_MS) : 1;
  localparam int IW  = (P_LED_NUMBER > 1) ? $clog2(P_LED_NUMBER) : 1;
  localparam logic [SW-1:0] STEP_LAST = SW'(P_STEP_MS - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(P_LED_NUMBER - 1);
  // XOR mask turning a "lit" pattern into pin levels (and back).
  localparam logic [P_LED_NUMBER-1:0] OFF_LVL = P_LED_ON ? '0 : '1;
  localparam logic [P_LED_NUMBER-1:0] LED_ONE = P_LED_NUMBER'(1);

  state_e                  state_q, state_d;
  logic [1:0]              pend_q, pend_d;
  logic [1:0]              mode_q, mode_d;
  logic [P_LED_NUMBER-1:0] led_q, led_d;
  logic [IW-1:0]           idx_q, idx_d, idx_nxt;
  logic [SW-1:0]           step_q, step_d;
  logic                    tick, step, accept, ready;
`ifdef LED_SEQ_BOUNCE_EN
  logic                    dir_up_q, dir_up_d, dir_up_nxt;
`endif

  led_ms_tick #(.P_CYCLES_PER_MS(CPM)) u_ms_tick (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clear (state_q != ST_RUN),
    .o_tick  (tick)
  );

  assign ready                = (state_q != ST_SWITCH);
  assign mode_if.o_mode_ready = ready;
  assign accept               = mode_if.i_mode_valid & ready;
  assign step                 = tick & (step_q == STEP_LAST);
  assign o_mode               = mode_q;
  assign o_led                = led_q;

  always_comb begin
    step_d = step_q;
    if (state_q != ST_RUN) begin
      step_d = '0;
    end else if (tick) begin
      step_d = (step_q == STEP_LAST) ? '0 : step_q + SW'(1);
    end
  end

  // Next lit position for CHASE.
  always_comb begin
    idx_nxt = idx_q;
`ifdef LED_SEQ_BOUNCE_EN
    dir_up_nxt = dir_up_q;
    if (P_LED_NUMBER > 1) begin
      if (dir_up_q) begin
        if (idx_q == IDX_LAST) begin
          dir_up_nxt = 1'b0;
          idx_nxt    = idx_q - IW'(1);
        end else begin
          idx_nxt = idx_q + IW'(1);
        end
      end else begin
        if (idx_q == '0) begin
          dir_up_nxt = 1'b1;
          idx_nxt    = idx_q + IW'(1);
        end else begin
          idx_nxt = idx_q - IW'(1);
        end
      end
    end
`else
    if (P_LED_NUMBER > 1) begin
      idx_nxt = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    mode_d  = mode_q;
    led_d   = led_q;
    idx_d   = idx_q;
`ifdef LED_SEQ_BOUNCE_EN
    dir_up_d = dir_up_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          pend_d  = mode_if.i_mode;
          state_d = ST_SWITCH;
          led_d   = OFF_LVL;
        end
      end
      ST_SWITCH: begin
        led_d = OFF_LVL;
        idx_d = '0;
`ifdef LED_SEQ_BOUNCE_EN
        dir_up_d = 1'b1;
`endif
        mode_d = pend_q;
        if (pend_q == MODE_OFF) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RUN;
          led_d   = ((pend_q == MODE_CHASE) ? LED_ONE : '1) ^ OFF_LVL;
        end
      end
      ST_RUN: begin
        // Acceptance outranks a coincident step: the step is dropped.
        if (accept) begin
          pend_d  = mode_if.i_mode;
          state_d = ST_SWITCH;
          led_d   = OFF_LVL;
        end else if (step) begin
          if (mode_q == MODE_BLINK) begin
            led_d = ~led_q;
          end else if (mode_q == MODE_CHASE) begin
            idx_d = idx_nxt;
            led_d = (LED_ONE << idx_nxt) ^ OFF_LVL;
`ifdef LED_SEQ_BOUNCE_EN
            dir_up_d = dir_up_nxt;
`endif
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        mode_d  = MODE_OFF;
        led_d   = OFF_LVL;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      pend_q  <= MODE_OFF;
      mode_q  <= MODE_OFF;
      led_q   <= OFF_LVL;
      idx_q   <= '0;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      mode_q  <= mode_d;
      led_q   <= led_d;
      idx_q   <= idx_d;
      step_q  <= step_d;
    end
  end

`ifdef LED_SEQ_BOUNCE_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      dir_up_q <= 1'b1;
    end else begin
      dir_up_q <= dir_up_d;
    end
  end
`endif

endmodule

// File: tb/tb_led_seq_ctrl.sv
// tb/tb_led_seq_ctrl.sv - directed self-checking bench for led_seq_ctrl
module tb_led_seq_ctrl;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic [1:0] o_mode;
  logic [3:0] o_led;
  int         checks = 0;
  int         failures = 0;

  led_seq_ctrl_if mif ();

  led_seq_ctrl #(
    .P_CLK_FREQ_HZ (10_000),
    .P_LED_NUMBER  (4),
    .P_STEP_MS     (3),
    .P_LED_ON      (1'b1)
  ) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .mode_if (mif.slave),
    .o_mode  (o_mode),
    .o_led   (o_led)
  );

  always #5 i_clk = ~i_clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then sample 1ns later.
  task automatic cycles(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  // Present a mode and return 1ns after the accepting edge (edge N).
  task automatic send(input logic [1:0] m);
    logic r;
    bit   done;
    done = 0;
    @(negedge i_clk);
    mif.i_mode       = m;
    mif.i_mode_valid = 1'b1;
    for (int i = 0; i < 8 && !done; i++) begin
      r = mif.o_mode_ready;
      @(posedge i_clk);
      if (r) done = 1;
      else @(negedge i_clk);
    end
    #1;
    mif.i_mode_valid = 1'b0;
    if (!done) check_eq("accept_timeout", 0, 1);
  endtask

  initial begin
    mif.i_mode       = 2'd0;
    mif.i_mode_valid = 1'b0;
    cycles(3);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    cycles(100);
    check_eq("idle_led", o_led, 4'b0000);
    check_eq("idle_mode", o_mode, 0);
    check_eq("idle_ready", mif.o_mode_ready, 1);

    // CHASE
    send(2'd3);
    check_eq("chase_sw_led", o_led, 4'b0000);
    check_eq("chase_sw_ready", mif.o_mode_ready, 0);
    cycles(1);
    check_eq("chase_n1_led", o_led, 4'b0001);
    check_eq("chase_n1_mode", o_mode, 3);
    check_eq("chase_n1_ready", mif.o_mode_ready, 1);
    cycles(29);
    check_eq("chase_n30_led", o_led, 4'b0001);
    cycles(1);
    check_eq("chase_n31_led", o_led, 4'b0010);
    cycles(30);
    check_eq("chase_n61_led", o_led, 4'b0100);
    cycles(30);
    check_eq("chase_n91_led", o_led, 4'b1000);
    cycles(30);
`ifdef LED_SEQ_BOUNCE_EN
    check_eq("chase_n121_led", o_led, 4'b0100);
`else
    check_eq("chase_n121_led", o_led, 4'b0001);
`endif

    // BLINK with valid held through SWITCH
    @(negedge i_clk);
    mif.i_mode       = 2'd2;
    mif.i_mode_valid = 1'b1;
    cycles(1);
    check_eq("hold_m_ready", mif.o_mode_ready, 0);
    check_eq("hold_m_led", o_led, 4'b0000);
    cycles(1);
    check_eq("hold_m1_ready", mif.o_mode_ready, 1);
    check_eq("hold_m1_led", o_led, 4'b1111);
    check_eq("hold_m1_mode", o_mode, 2);
    cycles(1);
    check_eq("hold_m2_ready", mif.o_mode_ready, 0);
    check_eq("hold_m2_led", o_led, 4'b0000);
    mif.i_mode_valid = 1'b0;
    cycles(1);
    check_eq("blink_r_led", o_led, 4'b1111);
    cycles(29);
    check_eq("blink_r29_led", o_led, 4'b1111);
    cycles(1);
    check_eq("blink_r30_led", o_led, 4'b0000);
    cycles(29);
    check_eq("blink_r59_led", o_led, 4'b0000);

    // Re-request BLINK on the step-strobe cycle: step discarded
    send(2'd2);
    check_eq("coinc_led", o_led, 4'b0000);
    check_eq("coinc_ready", mif.o_mode_ready, 0);
    cycles(1);
    check_eq("coinc_restart_led", o_led, 4'b1111);
    cycles(29);
    check_eq("coinc_r29_led", o_led, 4'b1111);
    cycles(1);
    check_eq("coinc_r30_led", o_led, 4'b0000);

    // Asynchronous reset mid-CHASE
    send(2'd3);
    cycles(31);
    check_eq("prerst_led", o_led, 4'b0010);
    #2;
    i_rst_n = 1'b0;
    #1;
    check_eq("rst_led", o_led, 4'b0000);
    check_eq("rst_mode", o_mode, 0);
    check_eq("rst_ready", mif.o_mode_ready, 1);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    cycles(40);
    check_eq("postrst_led", o_led, 4'b0000);
    check_eq("postrst_mode", o_mode, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
